// File: rtl/accumulator.sv
// Row-sum accumulator: pops (row, product) pairs from two FWFT FIFOs
// and writes one total per row run into the result memory.
module accumulator (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  row_id_out,
  input  logic        row_id_empty,
  output logic        row_id_rd_en,
  input  logic [15:0] mult_out,
  input  logic        mult_empty,
  output logic        mult_rd_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_en
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HELD
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cur_row;
  logic [15:0] r_acc;
  logic [7:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_wr_en;

  logic w_pop;
  logic w_same;

  assign w_pop  = !Reset && !row_id_empty && !mult_empty;
  assign w_same = (row_id_out == r_cur_row);

  assign row_id_rd_en = w_pop;
  assign mult_rd_en   = w_pop;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign wr_en        = r_wr_en;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cur_row <= 8'd0;
      r_acc     <= 16'd0;
      r_wr_addr <= 8'd0;
      r_wr_data <= 16'd0;
      r_wr_en   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_pop) begin
        if (r_state != IDLE && w_same) begin
          r_acc <= r_acc + mult_out;
        end else begin
          // HELD rows are already stored; only an unwritten ACC sum goes out
          if (r_state == ACC) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cur_row;
            r_wr_data <= r_acc;
          end
          r_cur_row <= row_id_out;
          r_acc     <= mult_out;
        end
        r_state <= ACC;
      end else if (r_state == ACC) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_cur_row;
        r_wr_data <= r_acc;
        r_state   <= HELD;
      end
    end
  end

endmodule

// File: tb/tb_accumulator.sv
// Scoreboard bench for accumulator: directed pairs push expected
// writes; a negedge monitor pops and compares every observed write.
module tb_accumulator;

  logic        Clk;
  logic        Reset;
  logic [7:0]  row_id_out;
  logic        row_id_empty;
  logic        row_id_rd_en;
  logic [15:0] mult_out;
  logic        mult_empty;
  logic        mult_rd_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];

  accumulator dut (
    .Clk(Clk),
    .Reset(Reset),
    .row_id_out(row_id_out),
    .row_id_empty(row_id_empty),
    .row_id_rd_en(row_id_rd_en),
    .mult_out(mult_out),
    .mult_empty(mult_empty),
    .mult_rd_en(mult_rd_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_en(wr_en)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (wr_en === 1'b1) begin
      logic [23:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   wr_addr, wr_data, e[23:16], e[15:0]);
        end
      end
    end
  end

  task automatic expect_wr(input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send(input logic [7:0] r, input logic [15:0] d);
    row_id_out   = r;
    mult_out     = d;
    row_id_empty = 1'b0;
    mult_empty   = 1'b0;
    #1;
    chk("rd_en_pop", {row_id_rd_en, mult_rd_en}, 2'b11);
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    row_id_empty = 1'b1;
    mult_empty   = 1'b1;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    Reset        = 1'b1;
    row_id_out   = 8'd0;
    mult_out     = 16'd0;
    row_id_empty = 1'b0;
    mult_empty   = 1'b0;
    #50;
    chk("rst_rd_en", {row_id_rd_en, mult_rd_en}, 2'b00);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    #50;
    chk("rst_rd_en_late", {row_id_rd_en, mult_rd_en}, 2'b00);
    #1;
    row_id_empty = 1'b1;
    mult_empty   = 1'b1;
    Reset        = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(8'd1, 16'd1);
      chk("acc_count", dut.r_acc, i + 1);
    end

    Reset = 1'b1;
    row_id_empty = 1'b0;
    mult_empty   = 1'b0;
    #1;
    chk("midrst_rd_en", {row_id_rd_en, mult_rd_en}, 2'b00);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    row_id_empty = 1'b1;
    mult_empty   = 1'b1;
    Reset        = 1'b0;
    idle(2);

    send(8'd1, 16'd1);
    send(8'd1, 16'd1);
    send(8'd1, 16'd1);
    expect_wr(8'd1, 16'd3);
    send(8'd2, 16'd5);
    chk("acc_row2", dut.r_acc, 5);
    expect_wr(8'd2, 16'd5);
    idle(4);
    chk("hold_addr", wr_addr, 8'd2);
    chk("hold_data", wr_data, 16'd5);

    send(8'd2, 16'd4);
    expect_wr(8'd2, 16'd9);
    idle(3);

    send(8'd3, 16'hFFFF);
    send(8'd3, 16'h0002);
    expect_wr(8'd3, 16'h0001);
    idle(3);

    send(8'd5, 16'd10);
    row_id_out   = 8'd5;
    mult_out     = 16'd7;
    row_id_empty = 1'b0;
    mult_empty   = 1'b1;
    #1;
    chk("mult_empty_rd_en", {row_id_rd_en, mult_rd_en}, 2'b00);
    expect_wr(8'd5, 16'd10);
    repeat (4) begin
      @(posedge Clk);
      #1;
    end
    chk("mult_empty_acc", dut.r_acc, 10);

    send(8'd6, 16'd1);
    expect_wr(8'd6, 16'd1);
    send(8'd5, 16'd2);
    expect_wr(8'd5, 16'd2);
    idle(4);
    chk("final_addr", wr_addr, 8'd5);
    chk("final_data", wr_data, 16'd2);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
